// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule, 16 words in, W[0..63] out.
// Ports: clk/rst_n (async active-low); start begins a block in IDLE;
// in_valid/in_ready/in_w load 16 message words; out_valid/out_ready/out_w/out_t/out_last
// emit one schedule word per accepted beat; busy outside IDLE; done pulses in FIN.

module mod_s0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module mod_s1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [5:0]  out_t,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_q, w_d;
  logic [31:0] wbuf_q [16];
  logic [31:0] wbuf_d [16];
  logic [3:0]  ti;
  logic [31:0] s0_y, s1_y, w_next;
  // Indices are for the word after t (n = t+1): n-2 = t+15, n-7 = t+10, n-15 = t+2, n-16 = t+1 (mod 16).
  // W[t] itself is still in w_q, so every operand comes from slots already written.
  assign ti = t_q[3:0];
  mod_s0 u_s0 (.x(wbuf_q[ti + 4'd2]),  .y(s0_y));
  mod_s1 u_s1 (.x(wbuf_q[ti + 4'd15]), .y(s1_y));
  assign w_next = (t_q < 6'd15) ? wbuf_q[ti + 4'd1]
                                : s1_y + wbuf_q[ti + 4'd10] + s0_y + wbuf_q[ti + 4'd1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    w_d     = w_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = 4'd0;
      end
      LOAD: if (in_valid) begin
        wbuf_d[cnt_q] = in_w;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = EMIT;
          t_d     = 6'd0;
          w_d     = wbuf_q[0];
        end
      end
      EMIT: if (out_ready) begin
        wbuf_d[ti] = w_q;
        t_d        = t_q + 6'd1;
        w_d        = w_next;
        if (t_q == 6'(ROUNDS - 1)) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      w_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      w_q     <= w_d;
    end
  end
  always_ff @(posedge clk) wbuf_q <= wbuf_d;
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == EMIT;
  assign out_w     = w_q;
  assign out_t     = t_q;
  assign out_last  = t_q == 6'(ROUNDS - 1);
  assign busy      = state_q != IDLE;
  assign done      = state_q == FIN;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: scoreboard bench for the SHA-256 message schedule.
module tb_sha256_msg_sched;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_w = 0;
  logic        in_ready, out_valid, out_last, busy, done;
  logic [31:0] out_w;
  logic [5:0]  out_t;

  sha256_msg_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
    .out_t(out_t), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] w; int t;} exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, passes = 0, beats = 0;
  logic [31:0] msg [16];
  logic [31:0] wref [64];
  bit          blk_done, last_acc, stalled;
  logic [31:0] held_w;
  logic [5:0]  held_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wref[t] = msg[t];
      else wref[t] = (rotr(wref[t-2], 17) ^ rotr(wref[t-2], 19) ^ (wref[t-2] >> 10))
                   + wref[t-7]
                   + (rotr(wref[t-15], 7) ^ rotr(wref[t-15], 18) ^ (wref[t-15] >> 3))
                   + wref[t-16];
      sb.push_back('{w: wref[t], t: t});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_acc = 0;
      stalled  = 0;
      beats    = 0;
    end else begin
      chk("done_pulse", done, last_acc);
      if (last_acc) begin
        chk("beat_count", beats, 64);
        beats    = 0;
        blk_done = 1;
      end
      if (stalled && out_valid) begin
        chk("stall_w", out_w, held_w);
        chk("stall_t", out_t, held_t);
      end
      last_acc = 0;
      stalled  = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL extra_beat: got beat t=%0d, expected none", out_t);
        end else begin
          e = sb.pop_front();
          chk($sformatf("out_w[%0d]", e.t), out_w, e.w);
          chk($sformatf("out_t[%0d]", e.t), out_t, e.t);
          chk($sformatf("out_last[%0d]", e.t), out_last, e.t == 63);
        end
        beats++;
        last_acc = out_t == 6'd63;
      end else if (out_valid) begin
        stalled = 1;
        held_w  = out_w;
        held_t  = out_t;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 16; i++)
      msg[i] = kind == 1 ? 32'h0 : kind == 2 ? 32'hFFFFFFFF : kind == 3 ? $urandom
             : i == 0 ? 32'h61626380 : i == 15 ? 32'h00000018 : 32'h0;
  endtask

  task automatic load(input bit gaps);
    int k;
    start = 1;
    step();
    start = 0;
    chk("busy_load", busy, 1);
    for (int i = 0; i < 16; i++) begin
      if (gaps && i == 8) begin
        in_valid = 0;
        start = 1;
        step();
        start = 0;
        step();
        step();
      end
      in_valid = 1;
      in_w = msg[i];
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        checks++;
        $display("FAIL in_ready_wait word %0d: got in_ready=0, expected 1", i);
      end
      step();
    end
    in_valid = 0;
  endtask

  task automatic emit(input bit rnd, input bit spur);
    bit did = 0;
    blk_done = 0;
    for (int c = 0; c < 3000 && !blk_done; c++) begin
      if (rnd && !did && out_valid && out_t == 6'd16) begin
        did = 1;
        out_ready = 0;
        repeat (10) step();
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = spur && (c == 20 || c == 40);
      in_valid  = 1'($urandom_range(0, 1));
      in_w      = $urandom;
      step();
    end
    out_ready = 0;
    start = 0;
    in_valid = 0;
    if (!blk_done) begin
      checks++;
      $display("FAIL done_timeout: got no DONE, expected DONE within budget");
    end
  endtask

  task automatic run_block(input int kind, input bit rnd, input bit gaps, input bit spur);
    fill(kind);
    build_ref();
    load(gaps);
    emit(rnd, spur);
    chk("sb_drained", sb.size(), 0);
    step();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_w", out_w, 0);
    chk("rst_out_t", out_t, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    step();
    step();
    chk_reset_outputs();
    rst_n = 1;
    step();
    run_block(0, 0, 0, 0);
    run_block(1, 0, 0, 0);
    run_block(2, 0, 0, 0);
    run_block(0, 1, 0, 0);
    run_block(0, 0, 1, 1);
    run_block(3, 1, 1, 1);
    run_block(3, 1, 0, 0);
    fill(0);
    build_ref();
    load(0);
    out_ready = 1;
    c = 0;
    while (!(out_valid && out_t == 6'd30) && c < 200) begin
      step();
      c++;
    end
    out_ready = 0;
    chk("reached_t30", out_t, 30);
    step();
    step();
    #2;
    rst_n = 0;
    #1;
    chk_reset_outputs();
    sb.delete();
    step();
    step();
    rst_n = 1;
    step();
    run_block(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
Message-schedule controller for the SHA-256 core. It accepts one 512-bit block as 16 x 32-bit words and emits the 64 schedule words W[0..63], one per accepted output beat. It sequences one MOD_S0 and one MOD_S1 instance over a 16-entry circular word buffer. It sits between the block loader and the compression-round controller.

Parameters:
ROUNDS, 64, number of schedule words emitted per block (fixed at 64; no other value supported)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  begin new block; sampled only in IDLE
IN_VALID  input  1  IN_W holds a message word
IN_READY  output  1  block accepts IN_W this cycle
IN_W  input  [0:31]  message word, index 0 = MSB
OUT_VALID  output  1  OUT_W/OUT_T valid
OUT_READY  input  1  consumer accepts the output beat
OUT_W  output  [0:31]  schedule word W[t], index 0 = MSB
OUT_T  output  6  round index t of OUT_W
OUT_LAST  output  1  high with the beat where OUT_T = 63
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse after the W[63] beat is accepted

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, load counter=0, t=0, buffer contents don't-care. Outputs: IN_READY=0, OUT_VALID=0, OUT_W=0, OUT_T=0, OUT_LAST=0, BUSY=0, DONE=0. Reset in any state aborts the block; partial output is discarded.
- States: IDLE, LOAD, EMIT, FIN.
- IDLE:
  - START=1 -> LOAD; load counter cleared.
  - START is ignored in every other state.
- LOAD:
  - IN_READY=1.
  - Each cycle with IN_VALID & IN_READY: buf[cnt] <= IN_W, cnt++.
  - After the 16th accepted word -> EMIT with t=0; IN_READY drops the following cycle.
  - No words are emitted during LOAD.
- EMIT:
  - OUT_VALID=1.
  - OUT_W = buf[t mod 16] for t<16.
  - For t>=16: OUT_W = MOD_S1(buf[(t-2) mod 16]) + buf[(t-7) mod 16] + MOD_S0(buf[(t-15) mod 16]) + buf[(t-16) mod 16], addition mod 2^32 with carries discarded.
  - The computed word is registered into OUT_W. On acceptance it overwrites buf[t mod 16]; this slot held W[t-16], which is no longer needed.
  - Beat handshake:
    - A beat completes on OUT_VALID & OUT_READY; then t++ and the next word is presented the following cycle. Sustained throughput is 1 word/cycle while OUT_READY=1.
    - OUT_VALID & !OUT_READY: OUT_W, OUT_T and OUT_LAST hold stable, and the buffer is not written.
  - OUT_LAST=1 iff OUT_T=63.
  - When the t=63 beat is accepted -> FIN.
- Latency:
  - First OUT_VALID is asserted 1 cycle after the 16th input word is accepted.
  - An unstalled block takes 16 load cycles + 64 emit cycles + 1 FIN cycle.
- FIN:
  - DONE=1 for exactly one cycle, OUT_VALID=0, then -> IDLE.
  - START asserted during FIN is ignored. START in the IDLE cycle that follows is honoured.
- BUSY=1 in LOAD, EMIT and FIN.
- MOD_S0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- MOD_S1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Both sigma functions are purely combinational. They are the team's existing modules and are instantiated, not re-coded.
- IN_VALID outside LOAD: ignored, and IN_READY is 0.
- OUT_READY outside EMIT: ignored.

Test Plan:
- "abc" block:
  - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018, OUT_READY=1.
  - Required: W[0..15] echoed unchanged with OUT_T=0..15; W[16]=0x61626380, W[17]=0x000F0000; OUT_LAST only at t=63; DONE pulses exactly one cycle later.
- All-zero block: all 64 OUT_W = 0x00000000; exactly 64 beats; OUT_T increments 0..63 with no gaps.
- All-ones block (16 x 0xFFFFFFFF): W[16] = 0x203FFFFC, checking the mod-2^32 wrap; W[0..15] all 0xFFFFFFFF.
- Backpressure:
  - Stimulus: "abc" block with OUT_READY toggling pseudo-randomly, including a 10-cycle stall at t=16.
  - Required: OUT_W/OUT_T stable throughout each stall; sequence identical to the unstalled run; no beat lost or duplicated.
- Input gaps and spurious START:
  - Stimulus: IN_VALID deasserted for 3 cycles mid-load; START pulsed during LOAD and EMIT.
  - Required: exactly 16 words captured in order; START has no effect; output matches the gap-free run.
- Reset mid-operation:
  - Stimulus: RST_N asserted at t=30 while stalled.
  - Required: all outputs go to reset values immediately, without waiting for a clock edge. A new START followed by the "abc" block then produces the correct full sequence from t=0.
